// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//
// Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// It has no adder of its own: every ITER cycle it borrows the shared
// single-cycle ALU for one add (shift/add multiply) or one subtract
// (restoring divide) and consumes the combinational result that same cycle.
//
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   Start_in       request, only honoured in IDLE or DONE
//   Op_in          00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with Start_in)
//   A_in, B_in     multiplicand/dividend and multiplier/divisor
//   Busy_out       high in PREP, ITER and FIX so the pipeline can stall
//   Done_out       one-cycle pulse in DONE, HI/LO already hold the result
//   Hi_out, Lo_out HI and LO registers
//   AluFunc_out, AluA_out, AluB_out   request to the shared ALU
//   AluResult_in   the shared ALU's combinational result

module muldiv_sequencer #(
   parameter int ITERATIONS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Start_in,
   input  logic [1:0]  Op_in,
   input  logic [31:0] A_in,
   input  logic [31:0] B_in,
   output logic        Busy_out,
   output logic        Done_out,
   output logic [31:0] Hi_out,
   output logic [31:0] Lo_out,
   output logic [5:0]  AluFunc_out,
   output logic [31:0] AluA_out,
   output logic [31:0] AluB_out,
   input  logic [31:0] AluResult_in
);

   localparam int CW = $clog2(ITERATIONS);
   localparam logic [CW-1:0] LAST_STEP = CW'(ITERATIONS - 1);
   localparam logic [5:0] FUNC_ADD = 6'b100000;
   localparam logic [5:0] FUNC_SUB = 6'b100010;

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [31:0]   aReg_q, aReg_d;
   logic [31:0]   bReg_q, bReg_d;
   logic          signA_q, signA_d;
   logic          signB_q, signB_d;
   logic [31:0]   opnd_q, opnd_d;
   logic [31:0]   workHi_q, workHi_d;
   logic [31:0]   workLo_q, workLo_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic        isSigned;
   logic        isDiv;
   logic [31:0] magA;
   logic [31:0] magB;
   logic [31:0] divShift;
   logic        divOut;
   logic        mulCarry;
   logic [63:0] product;
   logic [63:0] productNeg;
   logic        signsDiffer;

   // Operand decode and the arithmetic helpers used by the FSM below.
   // Magnitudes come straight from the latched raw operands; 0x80000000
   // negates to itself, which is exactly the unsigned magnitude we want.
   // The multiply carry is recovered from the 32-bit ALU sum by the usual
   // unsigned wrap test, and the divide "out" bit is the bit shifted off
   // the top of the partial remainder.
   assign isSigned    = op_q[0];
   assign isDiv       = op_q[1];
   assign magA        = (isSigned && aReg_q[31]) ? (32'd0 - aReg_q) : aReg_q;
   assign magB        = (isSigned && bReg_q[31]) ? (32'd0 - bReg_q) : bReg_q;
   assign divShift    = {workHi_q[30:0], workLo_q[31]};
   assign divOut      = workHi_q[31];
   assign mulCarry    = (AluResult_in < workHi_q);
   assign product     = {workHi_q, workLo_q};
   assign productNeg  = 64'd0 - product;
   assign signsDiffer = signA_q ^ signB_q;

   assign Hi_out = hi_q;
   assign Lo_out = lo_q;

   // Next-state and output logic.  Everything defaults to "hold" and the
   // ALU request defaults to an add of zeros so that the shared ALU sees a
   // harmless operation whenever we are not iterating.  HI/LO are only
   // written on the edge that enters DONE, so a stalled MFHI/MFLO keeps
   // reading the previous result for the whole operation.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      aReg_d      = aReg_q;
      bReg_d      = bReg_q;
      signA_d     = signA_q;
      signB_d     = signB_q;
      opnd_d      = opnd_q;
      workHi_d    = workHi_q;
      workLo_d    = workLo_q;
      count_d     = count_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      Busy_out    = 1'b0;
      Done_out    = 1'b0;
      AluFunc_out = FUNC_ADD;
      AluA_out    = 32'd0;
      AluB_out    = 32'd0;

      case (state_q)
         IDLE: begin
            if (Start_in) begin
               state_d = PREP;
               op_d    = Op_in;
               aReg_d  = A_in;
               bReg_d  = B_in;
            end
         end

         PREP: begin
            Busy_out = 1'b1;
            signA_d  = isSigned & aReg_q[31];
            signB_d  = isSigned & bReg_q[31];
            if (isDiv && (bReg_q == 32'd0)) begin
               // Divide by zero: skip the iterations and report the raw
               // dividend in HI with an all-ones quotient.
               hi_d    = aReg_q;
               lo_d    = 32'hFFFF_FFFF;
               state_d = DONE;
            end else begin
               count_d  = '0;
               workHi_d = 32'd0;
               workLo_d = isDiv ? magA : magB;
               opnd_d   = isDiv ? magB : magA;
               state_d  = ITER;
            end
         end

         ITER: begin
            Busy_out = 1'b1;
            if (isDiv) begin
               AluFunc_out = FUNC_SUB;
               AluA_out    = divShift;
               AluB_out    = opnd_q;
               if (divOut || (divShift >= opnd_q)) begin
                  workHi_d = AluResult_in;
                  workLo_d = {workLo_q[30:0], 1'b1};
               end else begin
                  workHi_d = divShift;
                  workLo_d = {workLo_q[30:0], 1'b0};
               end
            end else begin
               AluFunc_out = FUNC_ADD;
               AluA_out    = workHi_q;
               AluB_out    = opnd_q;
               if (workLo_q[0]) begin
                  workHi_d = {mulCarry, AluResult_in[31:1]};
                  workLo_d = {AluResult_in[0], workLo_q[31:1]};
               end else begin
                  workHi_d = {1'b0, workHi_q[31:1]};
                  workLo_d = {workHi_q[0], workLo_q[31:1]};
               end
            end
            if (count_q == LAST_STEP) begin
               state_d = FIX;
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         FIX: begin
            // Sign bits are only ever set for MULT/DIV, so unsigned ops
            // pass through unchanged.  The remainder follows the dividend.
            Busy_out = 1'b1;
            if (isDiv) begin
               lo_d = signsDiffer ? (32'd0 - workLo_q) : workLo_q;
               hi_d = signA_q ? (32'd0 - workHi_q) : workHi_q;
            end else begin
               hi_d = signsDiffer ? productNeg[63:32] : product[63:32];
               lo_d = signsDiffer ? productNeg[31:0] : product[31:0];
            end
            state_d = DONE;
         end

         DONE: begin
            Done_out = 1'b1;
            if (Start_in) begin
               state_d = PREP;
               op_d    = Op_in;
               aReg_d  = A_in;
               bReg_d  = B_in;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.  Reset is synchronous and clears every register,
   // including HI/LO, so a reset mid-operation simply abandons the work.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 2'd0;
         aReg_q   <= 32'd0;
         bReg_q   <= 32'd0;
         signA_q  <= 1'b0;
         signB_q  <= 1'b0;
         opnd_q   <= 32'd0;
         workHi_q <= 32'd0;
         workLo_q <= 32'd0;
         count_q  <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         aReg_q   <= aReg_d;
         bReg_q   <= bReg_d;
         signA_q  <= signA_d;
         signB_q  <= signB_d;
         opnd_q   <= opnd_d;
         workHi_q <= workHi_d;
         workLo_q <= workLo_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//
// Bench for muldiv_sequencer.  Provides the shared ALU, drives directed and
// random operations, and compares every cycle against a behavioural model
// that knows only the operation timeline and the arithmetic result.

module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        Start_in = 1'b0;
   logic [1:0]  Op_in = 2'd0;
   logic [31:0] A_in = 32'd0;
   logic [31:0] B_in = 32'd0;
   logic        Busy_out;
   logic        Done_out;
   logic [31:0] Hi_out;
   logic [31:0] Lo_out;
   logic [5:0]  AluFunc_out;
   logic [31:0] AluA_out;
   logic [31:0] AluB_out;
   logic [31:0] AluResult_in;

   muldiv_sequencer #(.ITERATIONS(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .Start_in     (Start_in),
      .Op_in        (Op_in),
      .A_in         (A_in),
      .B_in         (B_in),
      .Busy_out     (Busy_out),
      .Done_out     (Done_out),
      .Hi_out       (Hi_out),
      .Lo_out       (Lo_out),
      .AluFunc_out  (AluFunc_out),
      .AluA_out     (AluA_out),
      .AluB_out     (AluB_out),
      .AluResult_in (AluResult_in)
   );

   always #5 clock = ~clock;

   // The shared single-cycle ALU the sequencer borrows.
   assign AluResult_in = (AluFunc_out == 6'b100000) ? (AluA_out + AluB_out) :
                         (AluFunc_out == 6'b100010) ? (AluA_out - AluB_out) : 32'd0;

   int compared   = 0;
   int mismatched = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the instruction definitions.
   function automatic void referenceResult(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b,
                                           output logic [31:0] hi, output logic [31:0] lo);
      logic [63:0] p;
      logic [31:0] ma, mb, q, r;
      logic        sa, sb;
      sa = op[0] && a[31];
      sb = op[0] && b[31];
      ma = sa ? (32'd0 - a) : a;
      mb = sb ? (32'd0 - b) : b;
      if (!op[1]) begin
         if (op[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
         else       p = {32'd0, a} * {32'd0, b};
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         q  = ma / mb;
         r  = ma % mb;
         lo = (sa ^ sb) ? (32'd0 - q) : q;
         hi = sa ? (32'd0 - r) : r;
      end
   endfunction

   // Behavioural model: an accepted request keeps the unit busy for 34
   // cycles (1 for divide-by-zero), then HI/LO take the reference result
   // together with a one-cycle done pulse.
   bit          modelValid = 1'b0;
   int          busyLeft   = 0;
   bit          expDone    = 1'b0;
   logic [31:0] expHi = 32'd0, expLo = 32'd0;
   logic [31:0] pendHi = 32'd0, pendLo = 32'd0;
   logic [31:0] mMagA = 32'd0, mMagB = 32'd0;
   bit          mIsDiv = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         modelValid = 1'b1;
         busyLeft   = 0;
         expDone    = 1'b0;
         expHi      = 32'd0;
         expLo      = 32'd0;
      end else if (busyLeft > 0) begin
         busyLeft--;
         if (busyLeft == 0) begin
            expDone = 1'b1;
            expHi   = pendHi;
            expLo   = pendLo;
         end
      end else begin
         expDone = 1'b0;
         if (Start_in) begin
            referenceResult(Op_in, A_in, B_in, pendHi, pendLo);
            mIsDiv   = Op_in[1];
            mMagA    = (Op_in[0] && A_in[31]) ? (32'd0 - A_in) : A_in;
            mMagB    = (Op_in[0] && B_in[31]) ? (32'd0 - B_in) : B_in;
            busyLeft = (Op_in[1] && (B_in == 32'd0)) ? 1 : 34;
         end
      end
   end

   // Per-cycle comparison.  During the 32 iteration cycles the expected
   // ALU operands follow from the arithmetic: the multiply accumulator is
   // the partial product of the low k multiplier bits shifted down by k,
   // the divide operand is (prefix mod divisor) shifted left with the next
   // dividend bit appended.
   int          k;
   logic [63:0] partial, prefix, remv, rsv;

   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("busy", 64'(Busy_out), 64'(busyLeft > 0));
         checkOutput("done", 64'(Done_out), 64'(expDone));
         checkOutput("hi", 64'(Hi_out), 64'(expHi));
         checkOutput("lo", 64'(Lo_out), 64'(expLo));
         if (busyLeft >= 2 && busyLeft <= 33) begin
            k = 33 - busyLeft;
            if (mIsDiv) begin
               prefix = {32'd0, mMagA} >> (32 - k);
               remv   = prefix % {32'd0, mMagB};
               rsv    = (remv << 1) | 64'(mMagA[31 - k]);
               checkOutput("div_func", 64'(AluFunc_out), 64'(6'b100010));
               checkOutput("div_alu_a", 64'(AluA_out), 64'(rsv[31:0]));
               checkOutput("div_alu_b", 64'(AluB_out), 64'(mMagB));
            end else begin
               checkOutput("mul_func", 64'(AluFunc_out), 64'(6'b100000));
               if (mMagB[k]) begin
                  partial = 64'd0;
                  for (int i = 0; i < k; i++) begin
                     if (mMagB[i]) partial = partial + ({32'd0, mMagA} << i);
                  end
                  partial = partial >> k;
                  checkOutput("mul_alu_a", 64'(AluA_out), 64'(partial[31:0]));
                  checkOutput("mul_alu_b", 64'(AluB_out), 64'(mMagA));
               end
            end
         end else begin
            checkOutput("idle_func", 64'(AluFunc_out), 64'(6'b100000));
            checkOutput("idle_alu_a", 64'(AluA_out), 64'd0);
            checkOutput("idle_alu_b", 64'(AluB_out), 64'd0);
         end
      end
   end

   // Presents one request for a single edge, then scrambles the operand
   // inputs to show they are not looked at after sampling.  Returns at the
   // first falling edge after the sampling edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      Start_in = 1'b1;
      Op_in    = op;
      A_in     = a;
      B_in     = b;
      @(negedge clock);
      Start_in = 1'b0;
      Op_in    = 2'($urandom);
      A_in     = $urandom;
      B_in     = $urandom;
      checkOutput("busy_after_start", 64'(Busy_out), 64'd1);
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (!Done_out && cycles < 60) begin
         @(negedge clock);
         cycles++;
      end
      if (!Done_out) checkOutput("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic runDirected(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] hiLit,
                              input logic [31:0] loLit, input int latLit);
      int c;
      applyStimulus(op, a, b);
      waitDone(c);
      checkOutput({name, "_latency"}, 64'(c), 64'(latLit));
      checkOutput({name, "_hi"}, 64'(Hi_out), 64'(hiLit));
      checkOutput({name, "_lo"}, 64'(Lo_out), 64'(loLit));
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 20));
         4:       return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int c;
      bit sawDone;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      repeat (3) @(negedge clock);
      checkOutput("reset_busy", 64'(Busy_out), 64'd0);
      checkOutput("reset_done", 64'(Done_out), 64'd0);
      checkOutput("reset_hi", 64'(Hi_out), 64'd0);
      checkOutput("reset_lo", 64'(Lo_out), 64'd0);
      checkOutput("reset_func", 64'(AluFunc_out), 64'(6'b100000));
      reset = 1'b0;
      @(negedge clock);

      // Directed cases, issued back to back straight out of DONE.
      runDirected("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
      runDirected("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
      runDirected("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34);
      runDirected("divu", 2'b10, 32'd100, 32'd7, 32'h2, 32'hE, 34);
      runDirected("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      runDirected("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
      runDirected("divu_zero", 2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1);
      @(negedge clock);

      // A second request while busy must be ignored.
      applyStimulus(2'b00, 32'd5, 32'd3);
      repeat (9) @(negedge clock);
      Start_in = 1'b1;
      Op_in    = 2'b10;
      A_in     = 32'd9;
      B_in     = 32'd3;
      @(negedge clock);
      Start_in = 1'b0;
      waitDone(c);
      checkOutput("ignore_latency", 64'(c + 10), 64'd34);
      checkOutput("ignore_hi", 64'(Hi_out), 64'd0);
      checkOutput("ignore_lo", 64'(Lo_out), 64'd15);
      @(negedge clock);

      // Reset in the middle of an operation.
      runDirected("prior", 2'b00, 32'd641, 32'd6700417, 32'h1, 32'h1, 34);
      applyStimulus(2'b00, 32'd2, 32'd2);
      repeat (11) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("abort_busy", 64'(Busy_out), 64'd0);
      checkOutput("abort_done", 64'(Done_out), 64'd0);
      checkOutput("abort_hi", 64'(Hi_out), 64'd0);
      checkOutput("abort_lo", 64'(Lo_out), 64'd0);
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (Done_out) sawDone = 1'b1;
      end
      checkOutput("abort_no_done", 64'(sawDone), 64'd0);

      // Random operations with occasional ignored requests and random gaps.
      for (int n = 0; n < 60; n++) begin
         rop = 2'($urandom);
         ra  = pickOperand();
         rb  = pickOperand();
         applyStimulus(rop, ra, rb);
         if (!(rop[1] && rb == 32'd0) && ($urandom_range(0, 3) == 0)) begin
            repeat ($urandom_range(2, 25)) @(negedge clock);
            Start_in = 1'b1;
            Op_in    = 2'($urandom);
            A_in     = $urandom;
            B_in     = $urandom;
            @(negedge clock);
            Start_in = 1'b0;
         end
         waitDone(c);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      repeat (3) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO registers. It computes by issuing one add (Func 100000) or subtract (Func 100010) per cycle to a shared 32-bit ALU and consuming the ALU result. The block sits beside the single-cycle datapath. The processor stalls on Busy_out, and MFHI/MFLO read Hi_out and Lo_out.

Parameters:
ITERATIONS, 32, shift/add or shift/subtract steps per operation; must equal operand width.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Start_in  input  1  request; sampled only in IDLE or DONE
Op_in  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start_in
A_in  input  32  multiplicand / dividend; sampled with Start_in
B_in  input  32  multiplier / divisor; sampled with Start_in
Busy_out  output  1  high in PREP, ITER, FIX
Done_out  output  1  one-cycle pulse in DONE; Hi_out/Lo_out hold the new result
Hi_out  output  32  HI register
Lo_out  output  32  LO register
AluFunc_out  output  6  Func code to the shared ALU
AluA_out  output  32  ALU A operand
AluB_out  output  32  ALU B operand
AluResult_in  input  32  ALU O_out, combinational return in the same cycle

Behaviour:
- Reset value: state IDLE; Hi_out, Lo_out, count and the internal working registers are 0. Busy_out=0, Done_out=0.
- Idle ALU drive: outside ITER, AluFunc_out=100000 and AluA_out=AluB_out=0.
- States and transitions:
  - IDLE: Start_in -> PREP. The operands and op are latched.
  - PREP (1 cycle), signed ops: record both sign bits, then replace each operand with its two's-complement magnitude. 0x80000000 stays 0x80000000 and is treated as unsigned.
  - PREP, divide with divisor==0: go directly to DONE with Hi=A_in (raw) and Lo=0xFFFFFFFF. No ITER and no FIX.
  - PREP, all other cases: go to ITER with count=0.
  - ITER: exactly ITERATIONS cycles, count 0..31; at count==31 -> FIX.
  - FIX (1 cycle): apply the sign correction (see Sign correction) -> DONE. HI/LO are written on the FIX->DONE edge.
  - DONE (1 cycle): Done_out=1. Start_in -> PREP; otherwise -> IDLE.
- Multiply: 64-bit work register P. P={32'b0, multiplier} at the start of ITER; mcand is held separately.
  - If P[0]==1: drive ALU Func 100000 with A=P[63:32], B=mcand. sum=AluResult_in, carry=(sum<P[63:32]) unsigned. P <= {carry, sum, P[31:1]}.
  - If P[0]==0: P <= P>>1 (logical); the ALU is still driven but its result is ignored.
  - Final P = 64-bit unsigned product.
- Divide (restoring): remainder R=0, Q=dividend, D=divisor.
  - Each cycle: Rs={R[30:0],Q[31]} and out=R[31]. ALU Func 100010 with A=Rs, B=D.
  - If out | (Rs>=D unsigned): R<=AluResult_in and Q<={Q[30:0],1}.
  - Else: R<=Rs and Q<={Q[30:0],0}.
  - Final: Hi=R, Lo=Q.
- Sign correction:
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the dividend sign.
  - All results wrap mod 2^32/2^64. 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
- Latency: Start_in sampled at edge 0 gives Done_out high in the cycle after edge 34. Busy_out is high for cycles 1..34. The divide-by-zero path gives Done_out in the cycle after edge 1.
- Start_in while Busy_out=1 is ignored; the operation in flight is unaffected.
- Hi_out/Lo_out change only on entry to DONE; reads during Busy_out return the previous result.
- Reset mid-operation aborts to the reset state the next edge; no Done_out is produced.
- Op_in/A_in/B_in changes after the sampling edge have no effect.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done_out exactly 34 cycles after the start edge, Hi=0xFFFFFFFE, Lo=0x00000001. Busy_out high for 34 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- DIVU A=100, B=7 -> Lo=0x0000000E, Hi=0x00000002. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 -> Done_out in the cycle after edge 1, Hi=0x00001234, Lo=0xFFFFFFFF.
- Start MULTU 3*5, pulse Start_in with DIVU 9/3 at cycle 10 -> the second request is ignored; Hi=0, Lo=15 at DONE. A back-to-back Start_in in DONE begins a new op with no IDLE cycle.
- Start MULTU 2*2 after a prior result Hi=1/Lo=1, assert reset at cycle 12 -> no Done_out, Busy_out=0, Hi=Lo=0 next cycle. During ITER of MULTU 3*5, every cycle with P[0]=1 shows AluFunc_out=100000 and AluB_out=5.
